qcore_reg_access: RTL

QCORE_REG_ACCESS -- requirements
Module: qcore_reg_access

---
 rtl/qcore_reg_access.sv | 92 +++++++++
 1 files changed

// File: rtl/qcore_reg_access.sv
// qcore_reg_access: host register access arbitrated against core pipeline bank ports with a wait timeout
module qcore_reg_access #(
  parameter int WAIT_MAX = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [6:0]  req_addr_i,
  input  logic [31:0] req_dt_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dt_o,
  output logic        rsp_err_o,
  input  logic        core_we_i,
  input  logic        core_rd_i,
  output logic        bank_we_o,
  output logic [6:0]  bank_w_addr_o,
  output logic [31:0] bank_w_dt_o,
  output logic        bank_rd_sel_o,
  output logic [6:0]  bank_rd_addr_o,
  input  logic [31:0] bank_rd_dt_i
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);
  localparam logic [2:0] IDLE = 3'd0, WR_WAIT = 3'd1, RD_ADDR = 3'd2, RD_DATA = 3'd3, RESP = 3'd4;
  logic [2:0]    r_state, w_state_nxt;
  logic          r_wr, r_rsp_err;
  logic [6:0]    r_addr;
  logic [31:0]   r_dt, r_rsp_dt;
  logic [CW-1:0] r_cnt;
  logic          w_hs, w_illegal, w_blk, w_last, w_busy;
  logic [1:0]    w_page;
  logic [4:0]    w_idx;
  assign w_page = req_addr_i[6:5];
  assign w_idx = req_addr_i[4:0];
  assign w_hs = req_valid_i && r_state == IDLE;
  assign w_illegal = w_page == 2'b11 || (w_page == 2'b01 && w_idx > 5'd5) ||
                     (req_wr_i && w_page == 2'b10 && !(w_idx == 5'd1 || (w_idx >= 5'd12 && w_idx <= 5'd15)));
  assign w_blk = (r_state == WR_WAIT && core_we_i) || (r_state == RD_ADDR && core_rd_i);
  // the blocked cycle that brings the count to WAIT_MAX ends the wait; a grant in that cycle still wins
  assign w_last = r_cnt >= CNT_LAST;
  assign w_busy = r_state != IDLE;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = !w_hs ? IDLE : w_illegal ? RESP : req_wr_i ? WR_WAIT : RD_ADDR;
      WR_WAIT: w_state_nxt = (!core_we_i || w_last) ? RESP : WR_WAIT;
      RD_ADDR: w_state_nxt = !core_rd_i ? RD_DATA : w_last ? RESP : RD_ADDR;
      RD_DATA: w_state_nxt = RESP;
      RESP:    w_state_nxt = rsp_ready_i ? IDLE : RESP;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_dt      <= '0;
      r_cnt     <= '0;
      r_rsp_dt  <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_wr      <= req_wr_i;
        r_addr    <= req_addr_i;
        r_dt      <= req_dt_i;
        r_cnt     <= '0;
        r_rsp_dt  <= '0;
        r_rsp_err <= w_illegal;
      end
      if (w_blk) begin
        r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
        if (w_last) r_rsp_err <= 1'b1;
      end
      if (r_state == RD_DATA) r_rsp_dt <= bank_rd_dt_i;
    end
  end
  assign req_ready_o = r_state == IDLE;
  assign rsp_valid_o = r_state == RESP;
  assign rsp_dt_o = r_rsp_dt;
  assign rsp_err_o = r_rsp_err;
  assign bank_we_o = r_state == WR_WAIT && r_wr && !core_we_i;
  assign bank_rd_sel_o = r_state == RD_ADDR && !r_wr && !core_rd_i;
  assign bank_w_addr_o = w_busy ? r_addr : '0;
  assign bank_w_dt_o = w_busy ? r_dt : '0;
  assign bank_rd_addr_o = w_busy ? r_addr : '0;
endmodule
